ipc_mailbox: RTL and testbench

RIB slave that carries 32-bit messages between the two tinyriscv cores through two independent FIFO channels. Channel A carries core0→core1 traffic and channel B carries core1→core0 traffic. It is the responder end of the core-to-bus path: cores reach it through rib like rom/ram/timer/gpio, with no req_i and with combinational read data. Each channel raises a level interrupt toward its consumer core while it holds data and its interrupt is enabled.

---
 rtl/ipc_mailbox_pkg.sv | 35 +++
 rtl/ipc_mailbox_fifo.sv | 88 ++++++++
 rtl/ipc_mailbox.sv | 92 +++++++++
 tb/tb_ipc_mailbox.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ipc_mailbox_pkg.sv
// Shared constants for the inter-core mailbox: register offsets, bit positions
// and the STAT word packer used by the read mux.
package ipc_mailbox_pkg;

  localparam int MBX_DEPTH_DEFAULT = 8;

  localparam logic [1:0] MBX_PUSH = 2'd0;
  localparam logic [1:0] MBX_DATA = 2'd1;
  localparam logic [1:0] MBX_STAT = 2'd2;
  localparam logic [1:0] MBX_CTRL = 2'd3;

  localparam logic [31:0] MBX_CHB_BASE = 32'h0000_0010;

  localparam int STAT_CNT_LSB = 0;
  localparam int STAT_EMPTY   = 8;
  localparam int STAT_FULL    = 9;
  localparam int STAT_OVF     = 10;
  localparam int STAT_UDF     = 11;

  localparam int CTRL_IEN   = 0;
  localparam int CTRL_FLUSH = 1;

  function automatic logic [31:0] stat_word(input logic [7:0] cnt, input logic empty,
                                            input logic full, input logic ovf, input logic udf);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[STAT_CNT_LSB +: 8] = cnt;
    w[STAT_EMPTY]        = empty;
    w[STAT_FULL]         = full;
    w[STAT_OVF]          = ovf;
    w[STAT_UDF]          = udf;
    return w;
  endfunction

endpackage

// File: rtl/ipc_mailbox_fifo.sv
// One mailbox channel: circular buffer with occupancy count and sticky
// overflow/underflow flags. Storage is deliberately left unreset.
module mailbox_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic          clr_ovf,
  input  logic          clr_udf,
  input  logic [31:0]   wdata,
  output logic [31:0]   head,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          udf
);

  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [AW:0]   count_r;
  logic          ovf_r;
  logic          udf_r;
  logic          empty_s;
  logic          full_s;

  assign empty_s = (count_r == CNT_ZERO);
  assign full_s  = (count_r == CNT_FULL);

  // Storage write; only accepted pushes land in memory
  always_ff @(posedge clk) begin
    if (push && !full_s && !flush) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and sticky flags; a same-cycle set beats a W1C clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r  <= PTR_ZERO;
      rptr_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      if (clr_ovf) ovf_r <= 1'b0;
      if (clr_udf) udf_r <= 1'b0;
      if (flush) begin
        wptr_r  <= PTR_ZERO;
        rptr_r  <= PTR_ZERO;
        count_r <= CNT_ZERO;
      end else if (push) begin
        if (full_s) begin
          ovf_r <= 1'b1;
        end else begin
          wptr_r  <= wptr_r + PTR_ONE;
          count_r <= count_r + CNT_ONE;
        end
      end else if (pop) begin
        if (empty_s) begin
          udf_r <= 1'b1;
        end else begin
          rptr_r  <= rptr_r + PTR_ONE;
          count_r <= count_r - CNT_ONE;
        end
      end
    end
  end

  assign head  = empty_s ? 32'h0000_0000 : mem_r[rptr_r];
  assign count = count_r;
  assign empty = empty_s;
  assign full  = full_s;
  assign ovf   = ovf_r;
  assign udf   = udf_r;

endmodule

// File: rtl/ipc_mailbox.sv
// RIB slave mailbox between the two cores: channel A (core0->core1) at 0x00,
// channel B (core1->core0) at 0x10, each with a level IRQ to its consumer.
module ipc_mailbox
  import ipc_mailbox_pkg::*;
#(
  parameter int DEPTH = MBX_DEPTH_DEFAULT,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq_core1_o,
  output logic        irq_core0_o
);

  logic        ch_b_s;
  logic [1:0]  reg_sel_s;
  logic        wr_a_s, wr_b_s;
  logic        push_a_s, pop_a_s, stat_a_s, ctrl_a_s;
  logic        push_b_s, pop_b_s, stat_b_s, ctrl_b_s;
  logic        ien_a_r, ien_b_r;
  logic [31:0] head_a_s, head_b_s;
  logic [AW:0] count_a_s, count_b_s;
  logic        empty_a_s, full_a_s, ovf_a_s, udf_a_s;
  logic        empty_b_s, full_b_s, ovf_b_s, udf_b_s;
  logic [31:0] rdata_s;
  logic        unused_s;

  assign ch_b_s    = addr_i[4];
  assign reg_sel_s = addr_i[3:2];
  assign unused_s  = &{1'b0, addr_i[31:5], addr_i[1:0]};

  assign wr_a_s   = we_i & ~ch_b_s;
  assign wr_b_s   = we_i &  ch_b_s;
  assign push_a_s = wr_a_s & (reg_sel_s == MBX_PUSH);
  assign pop_a_s  = wr_a_s & (reg_sel_s == MBX_DATA);
  assign stat_a_s = wr_a_s & (reg_sel_s == MBX_STAT);
  assign ctrl_a_s = wr_a_s & (reg_sel_s == MBX_CTRL);
  assign push_b_s = wr_b_s & (reg_sel_s == MBX_PUSH);
  assign pop_b_s  = wr_b_s & (reg_sel_s == MBX_DATA);
  assign stat_b_s = wr_b_s & (reg_sel_s == MBX_STAT);
  assign ctrl_b_s = wr_b_s & (reg_sel_s == MBX_CTRL);

  mailbox_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo_a (
    .clk(clk), .rst(rst), .push(push_a_s), .pop(pop_a_s),
    .flush(ctrl_a_s & data_i[CTRL_FLUSH]),
    .clr_ovf(stat_a_s & data_i[STAT_OVF]), .clr_udf(stat_a_s & data_i[STAT_UDF]),
    .wdata(data_i), .head(head_a_s), .count(count_a_s),
    .empty(empty_a_s), .full(full_a_s), .ovf(ovf_a_s), .udf(udf_a_s)
  );

  mailbox_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo_b (
    .clk(clk), .rst(rst), .push(push_b_s), .pop(pop_b_s),
    .flush(ctrl_b_s & data_i[CTRL_FLUSH]),
    .clr_ovf(stat_b_s & data_i[STAT_OVF]), .clr_udf(stat_b_s & data_i[STAT_UDF]),
    .wdata(data_i), .head(head_b_s), .count(count_b_s),
    .empty(empty_b_s), .full(full_b_s), .ovf(ovf_b_s), .udf(udf_b_s)
  );

  // Interrupt-enable bits; flush is a pulse consumed by the FIFO directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ien_a_r <= 1'b0;
      ien_b_r <= 1'b0;
    end else begin
      if (ctrl_a_s) ien_a_r <= data_i[CTRL_IEN];
      if (ctrl_b_s) ien_b_r <= data_i[CTRL_IEN];
    end
  end

  // Side-effect-free read mux
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (reg_sel_s)
      MBX_PUSH: rdata_s = 32'h0000_0000;
      MBX_DATA: rdata_s = ch_b_s ? head_b_s : head_a_s;
      MBX_STAT: rdata_s = ch_b_s ?
                  stat_word(8'(count_b_s), empty_b_s, full_b_s, ovf_b_s, udf_b_s) :
                  stat_word(8'(count_a_s), empty_a_s, full_a_s, ovf_a_s, udf_a_s);
      MBX_CTRL: rdata_s = {31'h0000_0000, (ch_b_s ? ien_b_r : ien_a_r)};
      default:  rdata_s = 32'h0000_0000;
    endcase
  end

  assign data_o      = rdata_s;
  assign irq_core1_o = ien_a_r & ~empty_a_s;
  assign irq_core0_o = ien_b_r & ~empty_b_s;

endmodule

// File: tb/tb_ipc_mailbox.sv
// Directed walk through the mailbox behaviour followed by randomized traffic
// checked against a queue-based model of both channels.
module tb_ipc_mailbox;

  localparam int DEPTH = 8;
  localparam logic [31:0] A_PUSH = 32'h00, A_DATA = 32'h04, A_STAT = 32'h08, A_CTRL = 32'h0C;
  localparam logic [31:0] B_PUSH = 32'h10, B_DATA = 32'h14, B_STAT = 32'h18, B_CTRL = 32'h1C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] data_i = 32'h0;
  logic [31:0] data_o;
  logic        irq_core1_o, irq_core0_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic        m_ovf[2];
  logic        m_udf[2];
  logic        m_ien[2];

  ipc_mailbox dut (
    .clk(clk), .rst(rst), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .irq_core1_o(irq_core1_o), .irq_core0_o(irq_core0_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    qa.delete();
    qb.delete();
    for (int c = 0; c < 2; c++) begin
      m_ovf[c] = 1'b0;
      m_udf[c] = 1'b0;
      m_ien[c] = 1'b0;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int n;
    int c;
    logic [31:0] w;
    c = a[4] ? 1 : 0;
    n = (c == 1) ? qb.size() : qa.size();
    w = 32'h0;
    case (a[3:2])
      2'd1: if (n > 0) w = (c == 1) ? qb[0] : qa[0];
      2'd2: begin
        w[7:0] = 8'(n);
        w[8]   = (n == 0);
        w[9]   = (n == DEPTH);
        w[10]  = m_ovf[c];
        w[11]  = m_udf[c];
      end
      2'd3: w[0] = m_ien[c];
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d);
    int c;
    int n;
    c = a[4] ? 1 : 0;
    n = (c == 1) ? qb.size() : qa.size();
    case (a[3:2])
      2'd0: if (n < DEPTH) begin
              if (c == 1) qb.push_back(d); else qa.push_back(d);
            end else m_ovf[c] = 1'b1;
      2'd1: if (n > 0) begin
              if (c == 1) void'(qb.pop_front()); else void'(qa.pop_front());
            end else m_udf[c] = 1'b1;
      2'd2: begin
        if (d[10]) m_ovf[c] = 1'b0;
        if (d[11]) m_udf[c] = 1'b0;
      end
      default: begin
        m_ien[c] = d[0];
        if (d[1]) begin
          if (c == 1) qb.delete(); else qa.delete();
        end
      end
    endcase
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_i = a;
    data_i = d;
    we_i   = 1'b1;
    @(posedge clk);
    m_write(a, d);
    #1;
    we_i = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    we_i   = 1'b0;
    addr_i = a;
    #1;
    chk(tag, data_o, exp);
  endtask

  task automatic irqs(input string tag, input logic e1, input logic e0);
    @(negedge clk);
    #1;
    chk({tag, "_irq1"}, {31'h0, irq_core1_o}, {31'h0, e1});
    chk({tag, "_irq0"}, {31'h0, irq_core0_o}, {31'h0, e0});
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int kind;
    m_reset();
    #12 rst = 1'b0;

    // Asynchronous reset pulse between edges
    wr(A_PUSH, 32'h55);
    wr(B_PUSH, 32'h66);
    wr(A_CTRL, 32'h1);
    irqs("pre_rst", 1'b1, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    addr_i = A_STAT; #1 chk("rst_stat_a", data_o, 32'h100);
    addr_i = B_STAT; #1 chk("rst_stat_b", data_o, 32'h100);
    addr_i = A_DATA; #1 chk("rst_data_a", data_o, 32'h0);
    chk("rst_irq1", {31'h0, irq_core1_o}, 32'h0);
    chk("rst_irq0", {31'h0, irq_core0_o}, 32'h0);
    rst = 1'b0;
    m_reset();

    // Basic flow on channel A
    wr(A_PUSH, 32'h11);
    wr(A_PUSH, 32'h22);
    wr(A_PUSH, 32'h33);
    rd("basic_data", A_DATA, 32'h11);
    rd("basic_stat", A_STAT, 32'h003);
    irqs("basic_noien", 1'b0, 1'b0);
    wr(A_CTRL, 32'h1);
    irqs("basic_ien", 1'b1, 1'b0);
    wr(A_DATA, 32'hFFFF_FFFF);
    rd("pop1", A_DATA, 32'h22);
    wr(A_DATA, 32'h0);
    rd("pop2", A_DATA, 32'h33);
    irqs("pop2", 1'b1, 1'b0);
    wr(A_DATA, 32'h0);
    rd("pop3", A_DATA, 32'h0);
    irqs("pop3", 1'b0, 1'b0);

    // Full and overflow on channel B
    for (int i = 1; i <= 8; i++) wr(B_PUSH, 32'(i));
    rd("b_full", B_STAT, 32'h208);
    wr(B_PUSH, 32'h99);
    rd("b_ovf", B_STAT, 32'h608);
    for (int i = 1; i <= 8; i++) begin
      rd("b_drain", B_DATA, 32'(i));
      wr(B_DATA, 32'h0);
    end
    rd("b_empty", B_STAT, 32'h500);
    wr(B_STAT, 32'h400);
    rd("b_w1c", B_STAT, 32'h100);

    // Underflow on channel A
    wr(A_DATA, 32'h0);
    rd("udf", A_STAT, 32'h900);
    wr(A_STAT, 32'h800);
    rd("udf_w1c", A_STAT, 32'h100);

    // Pointer wrap on channel A
    for (int i = 0; i < 6; i++) wr(A_PUSH, 32'hA000 + 32'(i));
    for (int i = 0; i < 6; i++) begin
      rd("wrap1", A_DATA, 32'hA000 + 32'(i));
      wr(A_DATA, 32'h0);
    end
    for (int i = 0; i < 6; i++) wr(A_PUSH, 32'hB000 + 32'(i));
    rd("wrap_stat", A_STAT, 32'h006);
    for (int i = 0; i < 6; i++) begin
      rd("wrap2", A_DATA, 32'hB000 + 32'(i));
      if (i < 5) wr(A_DATA, 32'h0);
    end
    rd("wrap_cnt1", A_STAT, 32'h001);
    wr(A_CTRL, 32'h3);
    rd("flush_stat", A_STAT, 32'h100);
    rd("flush_ctrl", A_CTRL, 32'h1);
    irqs("flush", 1'b0, 1'b0);

    // Reset while a write is pending
    for (int i = 0; i < 5; i++) wr(A_PUSH, 32'hC0 + 32'(i));
    wr(A_CTRL, 32'h1);
    irqs("mid_pre", 1'b1, 1'b0);
    @(negedge clk);
    addr_i = A_PUSH;
    data_i = 32'hDEAD;
    we_i   = 1'b1;
    #1 rst = 1'b1;
    #1 chk("mid_irq1", {31'h0, irq_core1_o}, 32'h0);
    we_i   = 1'b0;
    addr_i = A_STAT;
    #1 chk("mid_stat", data_o, 32'h100);
    rst = 1'b0;
    m_reset();
    wr(A_PUSH, 32'hAB);
    rd("mid_push", A_DATA, 32'hAB);
    rd("mid_cnt", A_STAT, 32'h001);

    // Randomized traffic against the model, with aliased address bits
    for (int it = 0; it < 400; it++) begin
      kind = $urandom_range(0, 9);
      a = $urandom & 32'hFFFF_FFE3;
      a[4] = $urandom_range(0, 1) == 1;
      d = $urandom;
      if (kind < 4) begin
        a[3:2] = 2'd0;
      end else if (kind < 7) begin
        a[3:2] = 2'd1;
      end else if (kind == 7) begin
        a[3:2] = 2'd2;
      end else begin
        a[3:2] = 2'd3;
        d[1] = ($urandom_range(0, 7) == 0);
      end
      if (kind != 9) wr(a, d);
      a = $urandom;
      rd("rand_rd", a, m_read(a));
      irqs("rand", m_ien[0] && (qa.size() > 0), m_ien[1] && (qb.size() > 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
